// File: rtl/pdm_capture_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : pdm_capture_pkg
//  Description : Shared types and helpers for the PDM microphone capture
//                front end (write-strobe state encoding, counter helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package pdm_capture_pkg;

  // Write-strobe sequencer states
  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_PULSE1 = 2'd1,
    WR_PULSE2 = 2'd2,
    WR_HOLD   = 2'd3
  } wr_state_t;

  // Cycles din is held stable after wr falls, so the FIFO's falling-edge
  // detector can capture it
  localparam int c_hold_cycles = 2;

  // Saturating 8-bit increment used by the overrun counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_clk_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : pdm_clk_gen
//  Description : Divides the system clock down to the PDM microphone clock
//                and flags the cycle in which the mic clock rises.
//                Held in reset (clock low, divider cleared) while disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module pdm_clk_gen #(
  parameter int DIV_HALF = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  output logic o_mic_clk,
  output logic o_rise
);

  localparam int              c_cnt_w    = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [c_cnt_w-1:0] c_term_cnt = c_cnt_w'(DIV_HALF - 1);

  logic [c_cnt_w-1:0] r_div_cnt;
  logic               r_mic_clk;
  logic               w_term;

  assign w_term = i_enable && (r_div_cnt == c_term_cnt);

  // Half-period divider: toggle the mic clock at terminal count, idle low when disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_mic_clk <= 1'b0;
    end else if (!i_enable) begin
      r_div_cnt <= '0;
      r_mic_clk <= 1'b0;
    end else if (w_term) begin
      r_div_cnt <= '0;
      r_mic_clk <= ~r_mic_clk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Rise tick is the cycle whose clock edge takes the mic clock from 0 to 1
  assign o_rise    = w_term && !r_mic_clk;
  assign o_mic_clk = r_mic_clk;

endmodule
`default_nettype wire

// File: rtl/pdm_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : pdm_capture
//  Description : PDM microphone front end. Generates the mic clock, samples
//                the 1-bit stream, box-filters it into one PCM sample per
//                2^DEC_BITS mic clocks and pushes each sample into the PCM
//                FIFO with a falling-edge write pulse. Samples arriving while
//                the FIFO is full are dropped and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module pdm_capture
  import pdm_capture_pkg::*;
#(
  parameter int DIV_HALF = 25,
  parameter int DEC_BITS = 8,
  parameter int dbits    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             mic_data,
  input  logic             full,
  output logic             mic_clk,
  output logic             wr,
  output logic [dbits-1:0] din,
  output logic [7:0]       overrun
);

  logic                r_sync1;
  logic                r_sync2;
  logic                w_rise;
  logic [DEC_BITS:0]   r_ones;
  logic [DEC_BITS-1:0] r_edge;
  logic [DEC_BITS:0]   w_total;
  logic                w_win_end;
  logic [dbits-1:0]    w_pcm;
  wr_state_t           r_state;
  logic                r_hold_cnt;
  logic                r_wr;
  logic [dbits-1:0]    r_din;
  logic [7:0]          r_overrun;

  pdm_clk_gen #(
    .DIV_HALF (DIV_HALF)
  ) u_clk_gen (
    .clk       (clock),
    .rst       (reset),
    .i_enable  (enable),
    .o_mic_clk (mic_clk),
    .o_rise    (w_rise)
  );

  // Two-flop synchronizer for the asynchronous PDM data line
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= mic_data;
      r_sync2 <= r_sync1;
    end
  end

  // Running total including the bit sampled on the current rise tick, so the
  // last bit of a window is part of that window's sample
  assign w_total   = r_ones + (DEC_BITS + 1)'(r_sync2);
  assign w_win_end = w_rise && (r_edge == '1);

  // A window of all ones overflows the sample width; clamp it to full scale
  assign w_pcm = w_total[DEC_BITS] ? {dbits{1'b1}} : w_total[DEC_BITS-1 -: dbits];

  // Box-filter accumulation; disabling discards any partial window
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ones <= '0;
      r_edge <= '0;
    end else if (!enable) begin
      r_ones <= '0;
      r_edge <= '0;
    end else if (w_rise) begin
      r_edge <= r_edge + 1'b1;
      r_ones <= w_win_end ? '0 : w_total;
    end
  end

  // Write sequencer: wr high two cycles, then din held while the FIFO
  // detects the falling edge; full is only consulted at window end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= WR_IDLE;
      r_hold_cnt <= 1'b0;
      r_wr       <= 1'b0;
      r_din      <= '0;
      r_overrun  <= '0;
    end else begin
      case (r_state)
        WR_IDLE: begin
          if (w_win_end) begin
            if (full) begin
              r_overrun <= sat_inc8(r_overrun);
            end else begin
              r_din   <= w_pcm;
              r_wr    <= 1'b1;
              r_state <= WR_PULSE1;
            end
          end
        end
        WR_PULSE1: begin
          r_state <= WR_PULSE2;
        end
        WR_PULSE2: begin
          r_wr       <= 1'b0;
          r_hold_cnt <= 1'b0;
          r_state    <= WR_HOLD;
        end
        WR_HOLD: begin
          if (r_hold_cnt == 1'(c_hold_cycles - 1)) begin
            r_state <= WR_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= WR_IDLE;
        end
      endcase
    end
  end

  assign wr      = r_wr;
  assign din     = r_din;
  assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pdm_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pdm_capture
//  Description : Self-checking bench for pdm_capture. A microphone model
//                drives one PDM bit per mic clock rise and predicts each
//                window's PCM value into a scoreboard; a monitor pops and
//                compares on every write pulse. A second small instance
//                with the FIFO held full exercises overrun saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pdm_capture;

  localparam int DH        = 2;
  localparam int W         = 256;
  localparam int PERIOD    = 2 * DH * W;        // cycles between window ends
  localparam int FIRST_CYC = (2 * W - 1) * DH;  // enable -> first window end

  typedef enum int {M_ONE, M_ZERO, M_TOG, M_RAND} mode_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       mic_data = 1'b1;
  logic       full = 1'b0;
  logic       mic_clk;
  logic       wr;
  logic [7:0] din;
  logic [7:0] overrun;

  logic       reset2 = 1'b1;
  logic       enable2 = 1'b0;
  logic       mic_data2 = 1'b0;
  logic       full2 = 1'b1;
  logic       mic_clk2;
  logic       wr2;
  logic [3:0] din2;
  logic [7:0] overrun2;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  mode_t mode     = M_ONE;

  // microphone / reference model state
  int   n_in_win = 0;
  int   ones     = 0;
  int   n_win    = 0;
  int   exp_ovr  = 0;
  int   last_pcm = 0;
  int   pcm;
  logic prev_mic_clk = 1'b0;
  bit   have_prev = 1'b0;
  int   prev_rise_cyc = 0;
  int   exp_q[$];
  int   fifo_q[$];

  // monitor state
  logic prev_wr = 1'b0;
  int   wr_hi = 0;
  int   n_wr = 0;
  int   last_wr_cyc = 0;
  int   hold_left = -1;
  int   pend_din = 0;

  int   wr2_hi = 0;
  bit   done2 = 1'b0;

  pdm_capture #(.DIV_HALF(DH), .DEC_BITS(8), .dbits(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .mic_data (mic_data),
    .full     (full),
    .mic_clk  (mic_clk),
    .wr       (wr),
    .din      (din),
    .overrun  (overrun)
  );

  pdm_capture #(.DIV_HALF(DH), .DEC_BITS(4), .dbits(4)) dut_sat (
    .clock    (clock),
    .reset    (reset2),
    .enable   (enable2),
    .mic_data (mic_data2),
    .full     (full2),
    .mic_clk  (mic_clk2),
    .wr       (wr2),
    .din      (din2),
    .overrun  (overrun2)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic go();
    @(negedge clock);
    #2;
  endtask

  function automatic int fifo_last();
    return (fifo_q.size() != 0) ? fifo_q[$] : -1;
  endfunction

  // Microphone model: a new bit is presented after each mic clock rise and is
  // counted on the following rise; every W counted bits form one sample.
  always @(negedge clock) begin
    if (reset) begin
      n_in_win = 0; ones = 0; have_prev = 1'b0; exp_ovr = 0; last_pcm = 0;
      exp_q.delete();
      prev_mic_clk = 1'b0;
    end else begin
      if (!enable) begin
        n_in_win = 0; ones = 0; have_prev = 1'b0;
        if (mode == M_ONE) mic_data = 1'b1;
        else if (mode == M_ZERO) mic_data = 1'b0;
      end
      if (mic_clk && !prev_mic_clk) begin
        if (have_prev) check("mic_clk_period", cyc - prev_rise_cyc, 2 * DH);
        have_prev = 1'b1;
        prev_rise_cyc = cyc;
        ones += int'(mic_data);
        n_in_win++;
        if (n_in_win == W) begin
          pcm = (ones > 255) ? 255 : ones;
          if (full) exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
          else begin
            exp_q.push_back(pcm);
            last_pcm = pcm;
          end
          n_win++; n_in_win = 0; ones = 0;
        end
        case (mode)
          M_ONE:   mic_data = 1'b1;
          M_ZERO:  mic_data = 1'b0;
          M_TOG:   mic_data = ~mic_data;
          default: mic_data = 1'($urandom_range(0, 1));
        endcase
      end
      prev_mic_clk = mic_clk;
    end
  end

  // Monitor: compare each write against the scoreboard, check pulse width and
  // capture din into a FIFO model two cycles after wr falls
  always begin
    int e;
    @(negedge clock);
    #1;
    if (reset) begin
      prev_wr = 1'b0; wr_hi = 0; hold_left = -1;
    end else begin
      if (wr && !prev_wr) begin
        n_wr++;
        last_wr_cyc = cyc;
        check("wr_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("din", din, e);
          pend_din = e;
        end
        check("overrun_at_wr", overrun, exp_ovr);
      end
      if (wr) wr_hi++;
      if (!wr && prev_wr) begin
        check("wr_width", wr_hi, 2);
        wr_hi = 0;
        hold_left = 2;
      end else if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) begin
          check("din_hold", din, pend_din);
          fifo_q.push_back(int'(din));
          hold_left = -1;
        end
      end
      prev_wr = wr;
    end
  end

  task automatic wait_wr(input int target, input string name);
    int k = 0;
    while (n_wr < target && k < 4 * PERIOD) begin go(); k++; end
    check({name, "_wr_timeout"}, 32'(n_wr >= target), 1);
  endtask

  task automatic wait_pos(input int pos, input string name);
    int k = 0;
    while (n_in_win != pos && k < 2 * PERIOD) begin go(); k++; end
    check({name, "_pos_timeout"}, 32'(n_in_win == pos), 1);
  endtask

  // Saturation instance: FIFO always full, 16-bit windows of 64 cycles
  always @(negedge clock) begin
    mic_data2 = 1'($urandom_range(0, 1));
    if (!reset2 && wr2) wr2_hi++;
  end

  initial begin
    repeat (3) go();
    check("sat_rst_overrun", overrun2, 0);
    check("sat_rst_din", din2, 0);
    reset2 = 1'b0;
    go();
    enable2 = 1'b1;
    repeat (1280) @(posedge clock);
    @(negedge clock);
    #1;
    check("sat_overrun_20", overrun2, 20);
    repeat (300 * 64) @(posedge clock);
    @(negedge clock);
    #1;
    check("sat_overrun_255", overrun2, 255);
    check("sat_wr_never", wr2_hi, 0);
    done2 = 1'b1;
  end

  initial begin
    int c0;
    int w0;
    int nw;
    int hi;

    // reset state
    repeat (4) go();
    check("rst_mic_clk", mic_clk, 0);
    check("rst_wr", wr, 0);
    check("rst_din", din, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    repeat (2) go();

    // constant ones: first window timing and full-scale value
    mode = M_ONE;
    c0 = cyc;
    enable = 1'b1;
    wait_wr(1, "ones");
    check("first_wr_cycle", last_wr_cyc - c0, FIRST_CYC);
    repeat (5) go();
    check("fifo_ff", fifo_last(), 255);

    // constant zeros: window spacing
    mode = M_ZERO;
    wait_wr(3, "zeros");
    w0 = last_wr_cyc;
    wait_wr(4, "zeros2");
    check("window_spacing", last_wr_cyc - w0, PERIOD);
    check("din_zero", din, 0);

    // alternating bits: half scale
    mode = M_TOG;
    wait_wr(6, "toggle");
    repeat (5) go();
    check("fifo_80", fifo_last(), 8'h80);

    // random bits
    mode = M_RAND;
    wait_wr(9, "random");

    // FIFO full across one window end
    wait_pos(10, "full");
    full = 1'b1;
    w0 = n_win;
    nw = n_wr;
    while (n_win == w0 && cyc < 200000) go();
    full = 1'b0;
    go();
    check("overrun_one", overrun, 1);
    check("overrun_model", overrun, exp_ovr);
    check("din_kept", din, last_pcm);
    check("no_wr_when_full", n_wr, nw);
    wait_wr(nw + 1, "after_full");

    // disable mid-window, re-enable with ones
    wait_pos(100, "disable");
    enable = 1'b0;
    mode = M_ONE;
    go();
    hi = 0;
    repeat (200) begin
      go();
      if (mic_clk) hi++;
    end
    check("mic_clk_disabled", hi, 0);
    nw = n_wr;
    c0 = cyc;
    enable = 1'b1;
    wait_wr(nw + 1, "reenable");
    check("reenable_wr_cycle", last_wr_cyc - c0, FIRST_CYC);
    check("reenable_din", din, 8'hFF);

    // asynchronous reset mid-operation
    wait_pos(50, "reset");
    reset = 1'b1;
    #1;
    check("arst_mic_clk", mic_clk, 0);
    check("arst_wr", wr, 0);
    check("arst_din", din, 0);
    check("arst_overrun", overrun, 0);
    enable = 1'b0;
    go();
    reset = 1'b0;
    hi = 0;
    repeat (100) begin
      go();
      if (mic_clk || wr) hi++;
    end
    check("post_reset_idle", hi, 0);

    c0 = 0;
    while (!done2 && c0 < 40000) begin go(); c0++; end
    check("sat_done", 32'(done2), 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
